// File: rtl/ex_div_pkg.sv
// Shared encodings and sizes for the EX-stage multi-cycle divider.
package ex_div_pkg;

  localparam int DIV_STEPS = 32;
  localparam int RESULT_W  = 64;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

endpackage

// File: rtl/ex_div.sv
// EX-stage restoring divider (signed/unsigned), one quotient bit per cycle; stalls the pipe while busy.
// Optional macro DIV_ZERO_FAST_EN: a zero divisor finishes in two edges with a zero result.
module ex_div
  import ex_div_pkg::*;
#(
  parameter int DIV_W = DIV_STEPS
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 start_i,
  input  logic                 signed_i,
  input  logic [DIV_W-1:0]     opdata1_i,
  input  logic [DIV_W-1:0]     opdata2_i,
  input  logic                 annul_i,
  output logic [2*DIV_W-1:0]   result_o,
  output logic                 ready_o,
  output logic                 stallreq_o
);

  localparam int CW = $clog2(DIV_W);

  div_state_e           state, state_nxt;
  logic [CW-1:0]        cnt;
  logic [2*DIV_W:0]     work, work_step;
  logic [DIV_W-1:0]     dvsr, op1_abs, op2_abs, quo, rem;
  logic [DIV_W:0]       diff;
  logic                 neg_q, neg_r, last;

  assign op1_abs = (signed_i & opdata1_i[DIV_W-1]) ? (~opdata1_i + 1'b1) : opdata1_i;
  assign op2_abs = (signed_i & opdata2_i[DIV_W-1]) ? (~opdata2_i + 1'b1) : opdata2_i;

  // work[2*DIV_W] is always 0 while stepping (partial remainder < 2^(DIV_W-1)),
  // so including it leaves the 33-bit trial subtract unchanged.
  assign diff      = {work[2*DIV_W], work[2*DIV_W-1:DIV_W]} - {1'b0, dvsr};
  assign work_step = diff[DIV_W] ? {work[2*DIV_W-1:0], 1'b0}
                                 : {diff[DIV_W-1:0], work[DIV_W-1:0], 1'b1};
  assign quo  = work_step[DIV_W-1:0];
  assign rem  = work_step[2*DIV_W:DIV_W+1];
  assign last = (cnt == CW'(DIV_W-1));

  assign stallreq_o = start_i & ~ready_o & ~annul_i;

  always_comb begin
    state_nxt = state;
    if (annul_i) begin
      state_nxt = DivFree;
    end else begin
      case (state)
        DivFree: begin
          if (start_i) begin
`ifdef DIV_ZERO_FAST_EN
            state_nxt = (opdata2_i == '0) ? DivByZero : DivOn;
`else
            state_nxt = DivOn;
`endif
          end
        end
        DivByZero: state_nxt = DivEnd;
        DivOn:     if (last) state_nxt = DivEnd;
        DivEnd:    if (!start_i) state_nxt = DivFree;
        default:   state_nxt = DivFree;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= DivFree;
      cnt      <= '0;
      work     <= '0;
      dvsr     <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      result_o <= '0;
      ready_o  <= 1'b0;
    end else begin
      state   <= state_nxt;
      ready_o <= (state_nxt == DivEnd);
      if (!annul_i) begin
        case (state)
          DivFree: begin
            if (start_i) begin
              work  <= {{DIV_W{1'b0}}, op1_abs, 1'b0};
              dvsr  <= op2_abs;
              neg_q <= signed_i & (opdata1_i[DIV_W-1] ^ opdata2_i[DIV_W-1]);
              neg_r <= signed_i & opdata1_i[DIV_W-1];
              cnt   <= '0;
            end
          end
          DivOn: begin
            work <= work_step;
            cnt  <= cnt + 1'b1;
            if (last)
              result_o <= {(neg_r ? (~rem + 1'b1) : rem),
                           (neg_q ? (~quo + 1'b1) : quo)};
          end
          DivByZero: result_o <= '0;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ex_div.sv
// Self-checking bench for ex_div: vector table, random model checks and multi-cycle corner sequences.
module tb_ex_div;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        start_i = 1'b0;
  logic        signed_i = 1'b0;
  logic [31:0] opdata1_i = '0;
  logic [31:0] opdata2_i = '0;
  logic        annul_i = 1'b0;
  logic [63:0] result_o;
  logic        ready_o;
  logic        stallreq_o;

  ex_div #(.DIV_W(32)) dut (
    .clk(clk), .resetn(resetn), .start_i(start_i), .signed_i(signed_i),
    .opdata1_i(opdata1_i), .opdata2_i(opdata2_i), .annul_i(annul_i),
    .result_o(result_o), .ready_o(ready_o), .stallreq_o(stallreq_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
    int          hold;
  } vec_t;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [63:0] sb[$];
  logic [63:0] last_exp = '0;
  vec_t        tbl[10];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    int sa, sd;
    logic [31:0] q, r;
    if (sgn) begin
      sa = a; sd = b;
      q = 32'(sa / sd);
      r = 32'(sa % sd);
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  // Starts a division at a negedge, counts edges to ready, checks result/latency/stall length.
  task automatic run(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                     input logic [63:0] exp, input int lat, input int hold, input string nm);
    int n, st;
    logic [63:0] e;
    sb.push_back(exp);
    start_i = 1'b1; signed_i = sgn; opdata1_i = a; opdata2_i = b;
    n = 0; st = 0;
    #1;
    if (stallreq_o) st++;
    while (!ready_o && n < 200) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        opdata1_i = $urandom; opdata2_i = $urandom; signed_i = ~sgn;
      end
      if (stallreq_o) st++;
    end
    if (!ready_o) begin
      n_tests++; n_fail++;
      $display("FAIL %s timeout: ready_o not seen in %0d cycles, expected %0d", nm, n, lat);
    end
    if (sb.size() == 0) begin
      n_tests++; n_fail++;
      $display("FAIL %s scoreboard: got ready with empty queue, expected queued entry", nm);
      e = 'x;
    end else begin
      e = sb.pop_front();
    end
    chk({nm, " result"}, result_o, e);
    chk({nm, " latency"}, 64'(n), 64'(lat));
    chk({nm, " stall cycles"}, 64'(st), 64'(lat));
    last_exp = e;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({nm, " hold ready"}, 64'(ready_o), 64'd1);
      chk({nm, " hold result"}, result_o, e);
      chk({nm, " hold stallreq"}, 64'(stallreq_o), 64'd0);
    end
    start_i = 1'b0;
    @(negedge clk);
    chk({nm, " ready clears"}, 64'(ready_o), 64'd0);
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic        rs;

    tbl[0] = '{1'b0, 32'd100,        32'd7,        {32'd2,        32'd14},        0};
    tbl[1] = '{1'b1, 32'hFFFFFFF9,   32'd2,        {32'hFFFFFFFF, 32'hFFFFFFFD},  0};
    tbl[2] = '{1'b1, 32'h80000000,   32'hFFFFFFFF, {32'h0,        32'h80000000},  0};
    tbl[3] = '{1'b0, 32'hFFFFFFFF,   32'd1,        {32'h0,        32'hFFFFFFFF},  3};
    tbl[4] = '{1'b1, 32'd7,          32'hFFFFFFFE, {32'd1,        32'hFFFFFFFD},  0};
    tbl[5] = '{1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9, {32'hFFFFFFFE, 32'd14},        0};
    tbl[6] = '{1'b0, 32'h80000000,   32'd3,        {32'd2,        32'h2AAAAAAA},  0};
    tbl[7] = '{1'b0, 32'd5,          32'd9,        {32'd5,        32'd0},         0};
    tbl[8] = '{1'b0, 32'hFFFFFFFF,   32'hFFFFFFFF, {32'd0,        32'd1},         0};
    tbl[9] = '{1'b0, 32'hDEADBEEF,   32'h10,       {32'hF,        32'h0DEADBEE},  0};

    repeat (2) @(negedge clk);
    chk("reset ready", 64'(ready_o), 64'd0);
    chk("reset result", result_o, 64'd0);
    chk("reset stallreq", 64'(stallreq_o), 64'd0);
    resetn = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 10; i++)
      run(tbl[i].sgn, tbl[i].a, tbl[i].b, tbl[i].exp, 33, tbl[i].hold, $sformatf("vec%0d", i));

    for (int i = 0; i < 8; i++) begin
      rs = i[0];
      ra = $urandom;
      rb = $urandom >> (i * 3);
      if (rb == 0) rb = 32'd13;
      if (rs && ra == 32'h80000000 && rb == 32'hFFFFFFFF) rb = 32'd5;
      run(rs, ra, rb, model(rs, ra, rb), 33, 0, $sformatf("rand%0d", i));
    end

`ifdef DIV_ZERO_FAST_EN
    run(1'b0, 32'h1234, 32'd0, 64'h0, 2, 0, "div0 fast");
`else
    run(1'b0, 32'h1234, 32'd0, {32'h1234, 32'hFFFFFFFF}, 33, 0, "div0 full");
`endif

    // Flush at edge 10, idle at edge 11, restart at edge 12.
    start_i = 1'b1; signed_i = 1'b0; opdata1_i = 32'd1000; opdata2_i = 32'd10;
    repeat (10) @(negedge clk);
    annul_i = 1'b1;
    #1;
    chk("annul stallreq", 64'(stallreq_o), 64'd0);
    @(negedge clk);
    annul_i = 1'b0; start_i = 1'b0;
    #1;
    chk("annul ready", 64'(ready_o), 64'd0);
    chk("annul result held", result_o, last_exp);
    chk("annul idle stallreq", 64'(stallreq_o), 64'd0);
    @(negedge clk);
    run(1'b0, 32'd1000, 32'd10, {32'd0, 32'd100}, 33, 0, "post annul");

    // Asynchronous reset in the middle of a division.
    start_i = 1'b1; signed_i = 1'b0; opdata1_i = 32'd50; opdata2_i = 32'd5;
    repeat (15) @(negedge clk);
    start_i = 1'b0;
    #2;
    resetn = 1'b0;
    #1;
    chk("midrst ready", 64'(ready_o), 64'd0);
    chk("midrst result", result_o, 64'd0);
    chk("midrst stallreq", 64'(stallreq_o), 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    run(1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 33, 0, "post reset");

    if (sb.size() != 0) begin
      n_tests++; n_fail++;
      $display("FAIL scoreboard drain: got %0d entries left, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
